serial_adder: RTL and testbench

Bit-serial N-bit adder built around a single full-adder cell (a + b + carry -> 2-bit result) plus a registered carry. It adds one bit per clock, LSB first. It accepts two operands and a carry-in on a start pulse and reports the sum and carry-out with a done pulse. It sits downstream of the combinational full-adder cell and reuses it as its per-bit datapath.

---
 rtl/serial_adder_pkg.sv | 16 +
 rtl/serial_adder_full_adder.sv | 11 +
 rtl/serial_adder.sv | 96 +++++++++
 tb/tb_serial_adder.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: state encoding and default width.
package serial_adder_pkg;

    localparam int WIDTH_DEF = 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_RUN  = ST_RUN,
        S_DONE = ST_DONE
    } state_t;

endpackage

// File: rtl/serial_adder_full_adder.sv
// Combinational one-bit full adder; sum[1] is the carry, sum[0] the sum bit.
module full_adder (
    input  logic       a,
    input  logic       b,
    input  logic       x,
    output logic [1:0] sum
);

    assign sum = {1'b0, a} + {1'b0, b} + {1'b0, x};

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder, LSB first, one bit per clock through a single full adder.
//
// state  | meaning
// IDLE   | waiting for start; sum/cout hold the last result
// RUN    | one operand bit added per edge, carry kept in a register
// DONE   | done pulse cycle, returns to IDLE unconditionally
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter  int WIDTH = WIDTH_DEF,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_sh;
    logic             carry;
    logic [CNT_W-1:0] count;
    logic [1:0]       fa_sum;
    logic [WIDTH-1:0] sum_next;

    full_adder u_fa (
        .a   (a_sh[0]),
        .b   (b_sh[0]),
        .x   (carry),
        .sum (fa_sum)
    );

    // New bit enters at the MSB so after WIDTH shifts the LSB sits at bit 0.
    assign sum_next = (sum_sh >> 1) | (WIDTH'(fa_sum[0]) << (WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            sum    <= '0;
            cout   <= 1'b0;
            a_sh   <= '0;
            b_sh   <= '0;
            sum_sh <= '0;
            carry  <= 1'b0;
            count  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        carry <= cin;
                        count <= '0;
                        busy  <= 1'b1;
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    sum_sh <= sum_next;
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    carry  <= fa_sum[1];
                    count  <= count + CNT_W'(1);
                    if (count == CNT_W'(WIDTH - 1)) begin
                        sum   <= sum_next;
                        cout  <= fa_sum[1];
                        done  <= 1'b1;
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: an 8-bit instance for the main sequences and a 1-bit instance.
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       start = 1'b0;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic       cin = 1'b0;
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       cout;

    logic       start1 = 1'b0;
    logic [0:0] a1 = '0;
    logic [0:0] b1 = '0;
    logic       cin1 = 1'b0;
    logic       busy1;
    logic       done1;
    logic [0:0] sum1;
    logic       cout1;

    int passed = 0;
    int total  = 0;

    logic [7:0] last_sum  = '0;
    logic       last_cout = 1'b0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    serial_adder #(.WIDTH(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start1),
        .a     (a1),
        .b     (b1),
        .cin   (cin1),
        .busy  (busy1),
        .done  (done1),
        .sum   (sum1),
        .cout  (cout1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept one addition, optionally poke a competing start at edge 'inject' of RUN.
    task automatic run_add(input logic [7:0] av, input logic [7:0] bv, input logic cv,
                           input logic [7:0] exp_sum, input logic exp_cout,
                           input int inject, input string tag);
        int n;
        a = av; b = bv; cin = cv; start = 1'b1;
        tick();
        start = 1'b0;
        a = 8'h5A; b = 8'hC3; cin = ~cv;
        check({tag, "_busy_e0"}, busy, 1);
        n = 0;
        while (!done && n < 20) begin
            if (inject != 0 && n + 1 == inject) begin
                start = 1'b1; a = 8'hAA; b = 8'h55; cin = 1'b1;
            end
            tick();
            start = 1'b0;
            n++;
            if (!done) begin
                check({tag, "_busy_run"}, busy, 1);
                check({tag, "_sum_hold_run"}, {cout, sum}, {last_cout, last_sum});
            end
        end
        check({tag, "_latency"}, n, 8);
        check({tag, "_done"}, done, 1);
        check({tag, "_busy_done"}, busy, 1);
        check({tag, "_sum"}, sum, exp_sum);
        check({tag, "_cout"}, cout, exp_cout);
        last_sum = exp_sum;
        last_cout = exp_cout;
        tick();
        check({tag, "_done_pulse"}, done, 0);
        check({tag, "_busy_after"}, busy, 0);
    endtask

    initial begin
        int last_done;
        int ndone;
        logic prev_done;
        logic consec;
        int n;
        logic [2:0] v;

        #2;
        check("rst_outputs", {busy, done, cout, sum}, 0);
        #10 rst_n = 1'b1;
        tick();
        check("idle_after_reset", {busy, done, busy1, done1}, 0);

        run_add(8'h03, 8'h05, 1'b0, 8'h08, 1'b0, 0, "add_3_5");
        run_add(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 0, "add_ff_01");
        run_add(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 0, "add_ff_ff_c");
        run_add(8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 3, "ignore_start");

        a = 8'h77; b = 8'h99; cin = 1'b1;
        repeat (5) tick();
        check("sum_hold_idle", {busy, cout, sum}, {1'b0, 1'b0, 8'h30});

        // Held start: completions every WIDTH+2 cycles, never back to back.
        a = 8'h01; b = 8'h02; cin = 1'b0; start = 1'b1;
        last_done = -1; ndone = 0; prev_done = 1'b0; consec = 1'b0;
        for (int i = 0; i < 45; i++) begin
            tick();
            if (done && prev_done) consec = 1'b1;
            if (done) begin
                if (last_done >= 0) check("held_interval", i - last_done, 10);
                check("held_sum", {cout, sum}, 9'h003);
                last_done = i;
                ndone++;
            end
            prev_done = done;
        end
        start = 1'b0;
        check("held_no_consec", consec, 0);
        check("held_count", ndone >= 4, 1);
        n = 0;
        while (busy && n < 20) begin tick(); n++; end
        check("held_drain", busy, 0);
        last_sum = 8'h03; last_cout = 1'b0;

        // Reset in the middle of RUN clears outputs without waiting for a clock.
        a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        check("pre_reset_busy", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_reset_outputs", {busy, done, cout, sum}, 0);
        #3 rst_n = 1'b1;
        last_sum = '0; last_cout = 1'b0;
        tick();
        run_add(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 0, "after_reset");

        // WIDTH=1: every operand combination, done one edge after acceptance.
        for (int i = 0; i < 8; i++) begin
            v = i[2:0];
            a1 = v[2]; b1 = v[1]; cin1 = v[0]; start1 = 1'b1;
            tick();
            start1 = 1'b0;
            check("w1_busy", {busy1, done1}, 2'b10);
            tick();
            check("w1_done", done1, 1);
            check("w1_result", {cout1, sum1}, 2'(v[2]) + 2'(v[1]) + 2'(v[0]));
            tick();
            check("w1_idle", {busy1, done1}, 0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
